// File: rtl/activation_unit.sv
// rtl/activation_unit.sv - 3-stage requantize / activate / saturate pipeline for accumulator rows
// Optional macro ACT_ROUND_EN: round-half-up (toward +inf) before the requantize shift.
module activation_unit #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ACC_WIDTH    = 32,
  parameter int SHIFT        = 8,
  parameter int RELU6_MAX    = 96
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              valid_in,
  input  logic [MATRIX_WIDTH*ACC_WIDTH-1:0] acc_data_in,
  input  logic [3:0]                        activation_function,
  input  logic                              is_signed,
  input  logic [23:0]                       buf_addr_in,
  output logic [MATRIX_WIDTH*8-1:0]         act_data_out,
  output logic [23:0]                       buf_addr_out,
  output logic                              buf_write_en,
  output logic                              saturated
);
  localparam int QW = ACC_WIDTH + 1;
  localparam logic [3:0] ACT_RELU  = 4'd1;
  localparam logic [3:0] ACT_RELU6 = 4'd2;

  logic                              valid1, valid2;
  logic [MATRIX_WIDTH*ACC_WIDTH-1:0] acc1;
  logic [MATRIX_WIDTH*QW-1:0]        q_next, q2;
  logic [3:0]                        func1, func2;
  logic                              sign1, sign2;
  logic [23:0]                       addr1, addr2;
  logic [MATRIX_WIDTH*8-1:0]         act_next;
  logic                              sat_next, lane_sat;

  // One extra bit keeps both the sign-extended and the rounded unsigned value exact.
  function automatic logic [QW-1:0] requant(input logic [ACC_WIDTH-1:0] acc, input logic sgn);
    logic [QW-1:0] ext;
    logic [QW-1:0] q;
    ext = sgn ? {acc[ACC_WIDTH-1], acc} : {1'b0, acc};
`ifdef ACT_ROUND_EN
    ext = ext + (QW'(1) << (SHIFT - 1));
`endif
    if (sgn) q = $signed(ext) >>> SHIFT;
    else     q = ext >> SHIFT;
    return q;
  endfunction

  // Returns {clipped_by_output_saturation, result_byte}.
  function automatic logic [8:0] activate(input logic [QW-1:0] q, input logic [3:0] func,
                                          input logic sgn);
    logic signed [QW-1:0] v;
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    v = $signed(q);
    if ((func == ACT_RELU || func == ACT_RELU6) && v[QW-1]) v = '0;
    if (func == ACT_RELU6 && v > $signed(QW'(RELU6_MAX))) v = QW'(RELU6_MAX);
    hi = sgn ? QW'(127) : QW'(255);
    lo = sgn ? -QW'(128) : QW'(0);
    if (v > hi) return {1'b1, hi[7:0]};
    if (v < lo) return {1'b1, lo[7:0]};
    return {1'b0, v[7:0]};
  endfunction

  always_comb begin
    q_next = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++)
      q_next[i*QW +: QW] = requant(acc1[i*ACC_WIDTH +: ACC_WIDTH], sign1);
  end

  always_comb begin
    act_next = '0;
    sat_next = 1'b0;
    lane_sat = 1'b0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      {lane_sat, act_next[i*8 +: 8]} = activate(q2[i*QW +: QW], func2, sign2);
      sat_next = sat_next | lane_sat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1       <= 1'b0;
      valid2       <= 1'b0;
      buf_write_en <= 1'b0;
      acc1         <= '0;
      func1        <= '0;
      sign1        <= 1'b0;
      addr1        <= '0;
      q2           <= '0;
      func2        <= '0;
      sign2        <= 1'b0;
      addr2        <= '0;
      act_data_out <= '0;
      buf_addr_out <= '0;
      saturated    <= 1'b0;
    end else if (enable) begin
      valid1       <= valid_in;
      valid2       <= valid1;
      buf_write_en <= valid2;
      if (valid_in) begin
        acc1  <= acc_data_in;
        func1 <= activation_function;
        sign1 <= is_signed;
        addr1 <= buf_addr_in;
      end
      if (valid1) begin
        q2    <= q_next;
        func2 <= func1;
        sign2 <= sign1;
        addr2 <= addr1;
      end
      if (valid2) begin
        act_data_out <= act_next;
        saturated    <= sat_next;
        buf_addr_out <= addr2;
      end
    end
  end
endmodule

// File: tb/tb_activation_unit.sv
// tb/tb_activation_unit.sv - directed self-checking bench for activation_unit
module tb_activation_unit;
  localparam int MW = 14;
  localparam int AW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b1;
  logic             valid_in = 1'b0;
  logic [MW*AW-1:0] acc_data_in = '0;
  logic [3:0]       activation_function = 4'd0;
  logic             is_signed = 1'b1;
  logic [23:0]      buf_addr_in = '0;
  logic [MW*8-1:0]  act_data_out;
  logic [23:0]      buf_addr_out;
  logic             buf_write_en;
  logic             saturated;

  int n_cmp = 0;
  int n_bad = 0;

  activation_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in), .acc_data_in(acc_data_in),
    .activation_function(activation_function), .is_signed(is_signed), .buf_addr_in(buf_addr_in),
    .act_data_out(act_data_out), .buf_addr_out(buf_addr_out), .buf_write_en(buf_write_en),
    .saturated(saturated)
  );

  always #5 clk = ~clk;

  function automatic logic [MW*AW-1:0] fill(input logic [AW-1:0] v);
    logic [MW*AW-1:0] r;
    for (int i = 0; i < MW; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  function automatic logic [MW*AW-1:0] two(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [MW*AW-1:0] r;
    r = '0;
    r[AW-1:0] = a;
    r[2*AW-1:AW] = b;
    return r;
  endfunction

  function automatic logic [MW*8-1:0] fillb(input logic [7:0] v);
    logic [MW*8-1:0] r;
    for (int i = 0; i < MW; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [MW*8-1:0] twob(input logic [7:0] a, input logic [7:0] b);
    logic [MW*8-1:0] r;
    r = '0;
    r[7:0] = a;
    r[15:8] = b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [MW*AW-1:0] d, input logic [3:0] f, input logic s,
                       input logic [23:0] a);
    valid_in = 1'b1;
    acc_data_in = d;
    activation_function = f;
    is_signed = s;
    buf_addr_in = a;
  endtask

  task automatic run_beat(input logic [MW*AW-1:0] d, input logic [3:0] f, input logic s,
                          input logic [23:0] a);
    drive(d, f, s, a);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    drive(fill(32'h0000_0100), 4'd0, 1'b1, 24'h00ABCD);
    repeat (3) tick();
    valid_in = 1'b0;
    n_cmp++; if (buf_write_en !== 1'b0) begin n_bad++; $display("FAIL reset_bwe: got %b want 0", buf_write_en); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b want 0", saturated); end
    n_cmp++; if (act_data_out !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", act_data_out); end
    n_cmp++; if (buf_addr_out !== 24'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", buf_addr_out); end
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (buf_write_en !== 1'b0) begin n_bad++; $display("FAIL reset_release_bwe: got %b want 0", buf_write_en); end
  endtask

  task automatic test_basic();
    logic [7:0] e;
`ifdef ACT_ROUND_EN
    e = 8'h04;
`else
    e = 8'h03;
`endif
    drive(fill(32'h0000_0380), 4'd0, 1'b1, 24'h000084);
    tick();
    valid_in = 1'b0;
    tick();
    n_cmp++; if (buf_write_en !== 1'b0) begin n_bad++; $display("FAIL basic_early: got %b want 0", buf_write_en); end
    tick();
    n_cmp++; if (buf_write_en !== 1'b1) begin n_bad++; $display("FAIL basic_bwe: got %b want 1", buf_write_en); end
    n_cmp++; if (act_data_out !== fillb(e)) begin n_bad++; $display("FAIL basic_data: got %h want %h", act_data_out, fillb(e)); end
    n_cmp++; if (buf_addr_out !== 24'h000084) begin n_bad++; $display("FAIL basic_addr: got %h want 000084", buf_addr_out); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL basic_sat: got %b want 0", saturated); end
    tick();
    n_cmp++; if (buf_write_en !== 1'b0) begin n_bad++; $display("FAIL basic_one_cycle: got %b want 0", buf_write_en); end
  endtask

  task automatic test_relu();
    run_beat(two(32'hFFFF_FB00, 32'h0001_0000), 4'd1, 1'b1, 24'h000010);
    n_cmp++; if (act_data_out !== twob(8'h00, 8'h7F)) begin n_bad++; $display("FAIL relu_data: got %h want %h", act_data_out, twob(8'h00, 8'h7F)); end
    n_cmp++; if (saturated !== 1'b1) begin n_bad++; $display("FAIL relu_sat: got %b want 1", saturated); end
    run_beat(two(32'hFFFF_FB00, 32'h0001_0000), 4'd0, 1'b1, 24'h000011);
    n_cmp++; if (act_data_out !== twob(8'hFB, 8'h7F)) begin n_bad++; $display("FAIL noact_data: got %h want %h", act_data_out, twob(8'hFB, 8'h7F)); end
    n_cmp++; if (saturated !== 1'b1) begin n_bad++; $display("FAIL noact_sat: got %b want 1", saturated); end
    run_beat(two(32'hFFFF_FB00, 32'h0001_0000), 4'd7, 1'b1, 24'h000012);
    n_cmp++; if (act_data_out !== twob(8'hFB, 8'h7F)) begin n_bad++; $display("FAIL unknown_code_data: got %h want %h", act_data_out, twob(8'hFB, 8'h7F)); end
    run_beat(fill(32'h0000_7F00), 4'd2, 1'b1, 24'h000013);
    n_cmp++; if (act_data_out !== fillb(8'h60)) begin n_bad++; $display("FAIL relu6_data: got %h want %h", act_data_out, fillb(8'h60)); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL relu6_sat: got %b want 0", saturated); end
    run_beat(two(32'hFFFF_FB00, 32'h0000_3000), 4'd2, 1'b1, 24'h000014);
    n_cmp++; if (act_data_out !== twob(8'h00, 8'h30)) begin n_bad++; $display("FAIL relu6_neg_data: got %h want %h", act_data_out, twob(8'h00, 8'h30)); end
  endtask

  task automatic test_unsigned();
    run_beat(fill(32'h0000_FF00), 4'd0, 1'b0, 24'h000020);
    n_cmp++; if (act_data_out !== fillb(8'hFF)) begin n_bad++; $display("FAIL uns_max_data: got %h want %h", act_data_out, fillb(8'hFF)); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL uns_max_sat: got %b want 0", saturated); end
    run_beat(fill(32'h0001_0000), 4'd0, 1'b0, 24'h000021);
    n_cmp++; if (act_data_out !== fillb(8'hFF)) begin n_bad++; $display("FAIL uns_over_data: got %h want %h", act_data_out, fillb(8'hFF)); end
    n_cmp++; if (saturated !== 1'b1) begin n_bad++; $display("FAIL uns_over_sat: got %b want 1", saturated); end
    run_beat(two(32'hFFFF_FB00, 32'hFFFF_FFFF), 4'd1, 1'b0, 24'h000022);
    n_cmp++; if (act_data_out !== twob(8'hFF, 8'hFF)) begin n_bad++; $display("FAIL uns_relu_data: got %h want %h", act_data_out, twob(8'hFF, 8'hFF)); end
    n_cmp++; if (saturated !== 1'b1) begin n_bad++; $display("FAIL uns_relu_sat: got %b want 1", saturated); end
  endtask

  task automatic test_signed_bounds();
    run_beat(two(32'hFFFF_8000, 32'h0000_7F00), 4'd0, 1'b1, 24'h000030);
    n_cmp++; if (act_data_out !== twob(8'h80, 8'h7F)) begin n_bad++; $display("FAIL bound_exact_data: got %h want %h", act_data_out, twob(8'h80, 8'h7F)); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL bound_exact_sat: got %b want 0", saturated); end
    run_beat(two(32'hFFFF_7F00, 32'h0), 4'd0, 1'b1, 24'h000031);
    n_cmp++; if (act_data_out !== twob(8'h80, 8'h00)) begin n_bad++; $display("FAIL bound_under_data: got %h want %h", act_data_out, twob(8'h80, 8'h00)); end
    n_cmp++; if (saturated !== 1'b1) begin n_bad++; $display("FAIL bound_under_sat: got %b want 1", saturated); end
  endtask

  task automatic test_rounding();
    logic [7:0] ep;
    logic [7:0] en;
`ifdef ACT_ROUND_EN
    ep = 8'h02;
    en = 8'hFF;
`else
    ep = 8'h01;
    en = 8'hFE;
`endif
    run_beat(two(32'h0000_0180, 32'hFFFF_FE80), 4'd0, 1'b1, 24'h000040);
    n_cmp++; if (act_data_out !== twob(ep, en)) begin n_bad++; $display("FAIL round_data: got %h want %h", act_data_out, twob(ep, en)); end
  endtask

  task automatic test_capture();
    drive(two(32'hFFFF_FB00, 32'h0), 4'd1, 1'b1, 24'hABCDEF);
    tick();
    drive(fill(32'h0001_0000), 4'd0, 1'b0, 24'h111111);
    valid_in = 1'b0;
    tick();
    tick();
    n_cmp++; if (act_data_out !== '0) begin n_bad++; $display("FAIL capture_data: got %h want 0", act_data_out); end
    n_cmp++; if (buf_addr_out !== 24'hABCDEF) begin n_bad++; $display("FAIL capture_addr: got %h want abcdef", buf_addr_out); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL capture_sat: got %b want 0", saturated); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] got_addr [8];
    logic [7:0]  got_byte [8];
    int got;
    int k;
    got = 0;
    is_signed = 1'b1;
    activation_function = 4'd0;
    for (int s = 0; s < 12; s++) begin
      enable = !(s == 3 || s == 4);
      valid_in = (s < 7);
      if (s == 3 || s == 4) begin
        acc_data_in = fill(32'h0000_7700);
        buf_addr_in = 24'hDEAD00;
      end else begin
        k = (s < 3) ? s : s - 2;
        acc_data_in = fill(32'((k + 1) * 256));
        buf_addr_in = 24'h000100 + 24'(k);
      end
      tick();
      if (!enable) begin
        n_cmp++; if (buf_write_en !== 1'b1) begin n_bad++; $display("FAIL stall_bwe: got %b want 1", buf_write_en); end
        n_cmp++; if (buf_addr_out !== 24'h000100) begin n_bad++; $display("FAIL stall_addr: got %h want 000100", buf_addr_out); end
        n_cmp++; if (act_data_out[7:0] !== 8'h01) begin n_bad++; $display("FAIL stall_data: got %h want 01", act_data_out[7:0]); end
      end else if (buf_write_en && got < 8) begin
        got_addr[got] = buf_addr_out;
        got_byte[got] = act_data_out[7:0];
        got++;
      end
    end
    enable = 1'b1;
    valid_in = 1'b0;
    n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL b2b_count: got %0d want 5", got); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (got_addr[i] !== 24'h000100 + 24'(i)) begin n_bad++; $display("FAIL b2b_addr%0d: got %h want %h", i, got_addr[i], 24'h000100 + 24'(i)); end
      n_cmp++; if (got_byte[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, got_byte[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(fill(32'h0000_0A00), 4'd0, 1'b1, 24'h000200 + 24'(k));
      tick();
    end
    valid_in = 1'b0;
    n_cmp++; if (buf_write_en !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_bwe: got %b want 1", buf_write_en); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (buf_write_en !== 1'b0) begin n_bad++; $display("FAIL midrst_bwe: got %b want 0", buf_write_en); end
    n_cmp++; if (act_data_out !== '0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", act_data_out); end
    n_cmp++; if (buf_addr_out !== 24'h0) begin n_bad++; $display("FAIL midrst_addr: got %h want 0", buf_addr_out); end
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      if (buf_write_en) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_ghost: got %0d beats want 0", seen); end
    drive(fill(32'h0000_0500), 4'd0, 1'b1, 24'h000300);
    tick();
    valid_in = 1'b0;
    tick();
    n_cmp++; if (buf_write_en !== 1'b0) begin n_bad++; $display("FAIL midrst_early: got %b want 0", buf_write_en); end
    tick();
    n_cmp++; if (buf_write_en !== 1'b1) begin n_bad++; $display("FAIL midrst_next_bwe: got %b want 1", buf_write_en); end
    n_cmp++; if (buf_addr_out !== 24'h000300) begin n_bad++; $display("FAIL midrst_next_addr: got %h want 000300", buf_addr_out); end
    n_cmp++; if (act_data_out !== fillb(8'h05)) begin n_bad++; $display("FAIL midrst_next_data: got %h want %h", act_data_out, fillb(8'h05)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_unsigned();
    test_signed_bounds();
    test_rounding();
    test_capture();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 Parameter MATRIX_WIDTH, default 14: number of lanes per beat.
REQ-002 Parameter ACC_WIDTH, default 32: accumulator lane width, in bits.
REQ-003 Parameter SHIFT, default 8: requantization right-shift amount; legal range is 1..ACC_WIDTH-8.
REQ-004 Parameter RELU6_MAX, default 96: RELU6 upper clamp, as an 8-bit result value.
REQ-005 clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 enable, input, 1 bit: pipeline advance; when low, all pipeline state holds.
REQ-008 valid_in, input, 1 bit: beat valid; driven by buf_write_en of activation_flow_controller.
REQ-009 acc_data_in, input, MATRIX_WIDTH*ACC_WIDTH bits: accumulator row; lane i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-010 activation_function, input, activation_type (4 bits): 0 = NO_ACTIVATION, 1 = RELU, 2 = RELU6; any other code is treated as NO_ACTIVATION.
REQ-011 is_signed, input, 1 bit: selects two's-complement (1) or unsigned (0) arithmetic.
REQ-012 buf_addr_in, input, buffer_addr_type (24 bits): destination unified-buffer address.
REQ-013 act_data_out, output, MATRIX_WIDTH*8 bits: result row; lane i occupies bits [i*8 +: 8].
REQ-014 buf_addr_out, output, 24 bits: address that travels with act_data_out.
REQ-015 buf_write_en, output, 1 bit: result valid; drives the unified-buffer write.
REQ-016 saturated, output, 1 bit: set when any lane of the current output beat was clipped by output saturation.

Function
REQ-017 The block is a 3-stage pipeline (S1 capture, S2 requantize, S3 activate and saturate); input-to-output latency is exactly 3 enabled cycles.
REQ-018 activation_function, is_signed and buf_addr_in are captured in S1 together with the data and travel with the beat; a later change on these inputs does not affect beats already in flight.
REQ-019 When enable=1, each stage loads from the previous stage, and the valid bit propagates, including 0 for bubbles.
REQ-020 Data, address and flag registers load only when enable=1 and the incoming valid bit is 1; otherwise they hold their previous value.
REQ-021 When enable=0, all stages hold, buf_write_en holds its current value, and the valid_in of that cycle is dropped.
REQ-022 S2: q = acc >>> SHIFT (arithmetic shift) when signed, or acc >> SHIFT (logical shift) when unsigned; the computation uses an (ACC_WIDTH+1)-bit intermediate so no overflow occurs.
REQ-023 S3 RELU: signed q<0 gives 0; for unsigned beats RELU is the identity.
REQ-024 S3 RELU6: q is clamped to the range [0, RELU6_MAX]; when signed, negative values give 0.
REQ-025 S3 saturation, applied after activation: signed results clamp to [-128, 127]; unsigned results clamp to [0, 255]; the low 8 bits are emitted.
REQ-026 saturated = OR over all lanes of the condition "the REQ-025 clamp changed the value"; the RELU/RELU6 clamps do not count toward saturated.
REQ-027 Back-to-back valid beats are accepted every cycle, giving a throughput of 1 beat per enabled cycle.
REQ-028 The SHIFT, RELU6_MAX and lane-width arithmetic are identical for all lanes, and the lanes are independent of each other.

Reset
REQ-029 While rst=0, all valid bits, buf_write_en and saturated are 0, and act_data_out and buf_addr_out are all-zero; this takes effect immediately, without waiting for a clock edge.
REQ-030 Asserting reset in the middle of a stream discards all in-flight beats; after reset is released, the first buf_write_en is 3 enabled cycles after the next accepted valid_in.

Configuration
REQ-031 Macro ACT_ROUND_EN defined: S2 adds 2^(SHIFT-1) before shifting, giving round-half-up toward +infinity in both signed and unsigned modes, using the widened intermediate.
REQ-032 Macro ACT_ROUND_EN undefined: S2 truncates (floor for signed, plain shift for unsigned), and no rounding adder is instantiated.

Verification
REQ-033 Signed, NO_ACTIVATION, all lanes 0x00000380, addr 0x000084, valid for 1 cycle -> 3 cycles later buf_write_en=1 for exactly 1 cycle, every lane 0x03, buf_addr_out=0x000084, saturated=0.
REQ-034 Signed RELU, lane0=0xFFFFFB00 (-1280), lane1=0x00010000 -> lane0 0x00, lane1 0x7F, saturated=1; the same inputs with NO_ACTIVATION -> lane0 0xFB, lane1 0x7F.
REQ-035 Unsigned, NO_ACTIVATION, lane=0x0000FF00 -> 0xFF with saturated=0; lane=0x00010000 -> 0xFF with saturated=1. Signed RELU6, lane=0x00007F00 -> 0x60 with saturated=0.
REQ-036 Rounding, signed, lane=0x00000180 (1.5) and lane=0xFFFFFE80 (-1.5) -> with ACT_ROUND_EN: 0x02 and 0xFF; without ACT_ROUND_EN: 0x01 and 0xFE.
REQ-037 Stream of 5 back-to-back beats with enable deasserted for 2 cycles in the middle -> 5 output beats in order with addresses unchanged; buf_write_en holds its value during the stall; no beat is lost or duplicated.
REQ-038 rst pulsed low for 1 cycle while 3 beats are in flight -> outputs go to 0 immediately, none of the in-flight beats ever appears at the output, and the next beat after reset appears with 3-cycle latency.
